// File: rtl/fg_trapezoid_gen.sv
// ----------------------------------------------------------------------------
// fg_trapezoid_gen
// Trapezoid / PWM waveform stage of the function generator. Owns its own
// period counter, double-buffers all waveform settings so they only change at
// period boundaries, adds a saturating signed DC offset and supports
// continuous or triggered one-shot operation.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   clk_en_i            tick qualifier; state only advances when high
//   enable_i            run enable
//   oneshot_i           0 = continuous, 1 = one trapezoid per trigger
//   trigger_i           one-shot start request (only honoured in STOP)
//   period_i            last counter value of a period (period_i+1 ticks)
//   on_time_i           counter value at which the fall begins
//   k_rise_i, k_fall_i  unsigned slope steps per tick
//   amplitude_i         unsigned plateau value
//   offset_i            signed DC offset
//   out_o               saturated signed (val + offset)
//   period_start_o      one-cycle pulse after each start / wrap tick
//   busy_o              high while the generator is not stopped
// ----------------------------------------------------------------------------
module fg_trapezoid_gen #(
    parameter int unsigned COUNTER_BITWIDTH  = 32,
    parameter int unsigned WAVEFORM_BITWIDTH = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clk_en_i,
    input  logic                                enable_i,
    input  logic                                oneshot_i,
    input  logic                                trigger_i,
    input  logic        [COUNTER_BITWIDTH-1:0]  period_i,
    input  logic        [COUNTER_BITWIDTH-1:0]  on_time_i,
    input  logic        [WAVEFORM_BITWIDTH-1:0] k_rise_i,
    input  logic        [WAVEFORM_BITWIDTH-1:0] k_fall_i,
    input  logic        [WAVEFORM_BITWIDTH-1:0] amplitude_i,
    input  logic signed [WAVEFORM_BITWIDTH:0]   offset_i,
    output logic signed [WAVEFORM_BITWIDTH:0]   out_o,
    output logic                                period_start_o,
    output logic                                busy_o
);

    localparam int unsigned CW = COUNTER_BITWIDTH;
    localparam int unsigned W  = WAVEFORM_BITWIDTH;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_STOP,
        ST_RISE,
        ST_ON,
        ST_FALL,
        ST_LOW
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [W:0]         val_q;
    logic               period_start_q;
    logic               busy_q;

    // Shadow copies of the settings, refreshed only at period boundaries
    logic [CW-1:0]      period_q;
    logic [CW-1:0]      on_time_q;
    logic [W-1:0]       k_rise_q;
    logic [W-1:0]       k_fall_q;
    logic [W-1:0]       amp_q;
    logic signed [W:0]  offset_q;

    logic               start_req;
    logic               at_wrap;
    logic               at_on;
    logic               do_fall;
    logic               rise_full;
    logic               fall_empty;
    logic               shadow_load;
    logic [CW-1:0]      cnt_d;
    logic [W:0]         slope_d;
    logic [W:0]         kr_ext;
    logic [W:0]         kf_ext;
    logic [W:0]         amp_ext;
    logic signed [W+1:0] sum_d;

    assign start_req = enable_i && (!oneshot_i || trigger_i);
    assign at_wrap   = (cnt_q == period_q);
    assign at_on     = (cnt_q == on_time_q);
    assign cnt_d     = at_wrap ? '0 : cnt_q + CNT_ONE;
    assign kr_ext    = {1'b0, k_rise_q};
    assign kf_ext    = {1'b0, k_fall_q};
    assign amp_ext   = {1'b0, amp_q};

    // A fall step happens in FALL, or on the on_time tick of RISE/ON
    assign do_fall = (state_q == ST_FALL) ||
                     (((state_q == ST_RISE) || (state_q == ST_ON)) && at_on);

    // Single shared slope adder. val <= 2^W-1 so val+k_rise never overflows
    // W+1 bits, and subtraction is only used when val > k_fall.
    assign slope_d    = do_fall ? (val_q - kf_ext) : (val_q + kr_ext);
    assign rise_full  = (slope_d >= amp_ext);
    assign fall_empty = (val_q <= kf_ext);

    assign shadow_load = clk_en_i &&
                         (((state_q == ST_STOP) && start_req) ||
                          ((state_q != ST_STOP) && enable_i && at_wrap && !oneshot_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            period_q  <= '0;
            on_time_q <= '0;
            k_rise_q  <= '0;
            k_fall_q  <= '0;
            amp_q     <= '0;
            offset_q  <= '0;
        end else if (shadow_load) begin
            period_q  <= period_i;
            on_time_q <= on_time_i;
            k_rise_q  <= k_rise_i;
            k_fall_q  <= k_fall_i;
            amp_q     <= amplitude_i;
            offset_q  <= offset_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_STOP;
            cnt_q          <= '0;
            val_q          <= '0;
            period_start_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            // Pulse is one clk_i cycle wide regardless of clk_en_i
            period_start_q <= 1'b0;
            if (clk_en_i) begin
                if (state_q == ST_STOP) begin
                    cnt_q <= '0;
                    val_q <= '0;
                    if (start_req) begin
                        state_q        <= ST_RISE;
                        busy_q         <= 1'b1;
                        period_start_q <= 1'b1;
                    end
                end else if (!enable_i) begin
                    state_q <= ST_STOP;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    val_q   <= '0;
                end else if (at_wrap) begin
                    cnt_q <= '0;
                    if (oneshot_i) begin
                        state_q <= ST_STOP;
                        busy_q  <= 1'b0;
                        val_q   <= '0;
                    end else begin
                        // val is kept so a ramp carries across the boundary
                        state_q        <= ST_RISE;
                        period_start_q <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_d;
                    if (do_fall) begin
                        if (fall_empty) begin
                            val_q   <= '0;
                            state_q <= ST_LOW;
                        end else begin
                            val_q   <= slope_d;
                            state_q <= ST_FALL;
                        end
                    end else begin
                        case (state_q)
                            ST_RISE: begin
                                if (rise_full) begin
                                    val_q   <= amp_ext;
                                    state_q <= ST_ON;
                                end else begin
                                    val_q <= slope_d;
                                end
                            end
                            ST_ON:   val_q <= amp_ext;
                            default: val_q <= '0;
                        endcase
                    end
                end
            end
        end
    end

    // Output: W+2-bit signed sum, clamped to the W+1-bit signed range
    assign sum_d = $signed({1'b0, val_q}) + $signed({offset_q[W], offset_q});

    always_comb begin
        out_o = sum_d[W:0];
        if (sum_d[W+1] != sum_d[W]) begin
            out_o = sum_d[W+1] ? {1'b1, {W{1'b0}}} : {1'b0, {W{1'b1}}};
        end
    end

    assign period_start_o = period_start_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_fg_trapezoid_gen.sv
module tb_fg_trapezoid_gen;

    localparam int CW = 32;
    localparam int W  = 16;
    localparam longint OUT_MAX = (longint'(1) << W) - 1;
    localparam longint OUT_MIN = -(longint'(1) << W);

    logic                clk = 1'b0;
    logic                rst;
    logic                clk_en;
    logic                enable;
    logic                oneshot;
    logic                trigger;
    logic [CW-1:0]       period;
    logic [CW-1:0]       on_time;
    logic [W-1:0]        k_rise;
    logic [W-1:0]        k_fall;
    logic [W-1:0]        amp;
    logic signed [W:0]   offset;
    logic signed [W:0]   out;
    logic                pstart;
    logic                busy;

    fg_trapezoid_gen #(
        .COUNTER_BITWIDTH (CW),
        .WAVEFORM_BITWIDTH(W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clk_en_i      (clk_en),
        .enable_i      (enable),
        .oneshot_i     (oneshot),
        .trigger_i     (trigger),
        .period_i      (period),
        .on_time_i     (on_time),
        .k_rise_i      (k_rise),
        .k_fall_i      (k_fall),
        .amplitude_i   (amp),
        .offset_i      (offset),
        .out_o         (out),
        .period_start_o(pstart),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        longint out;
        bit     ps;
        bit     busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: waveform value as a function of the position in the
    // period. Before on_time the value climbs toward the plateau (clamped),
    // from on_time on it decays toward zero (clamped), the wrap tick holds it.
    bit     m_run;
    bit     m_ps;
    longint m_cnt, m_v;
    longint s_per, s_on, s_kr, s_kf, s_amp, s_off;

    function automatic void m_reset();
        m_run = 0; m_ps = 0; m_cnt = 0; m_v = 0;
        s_per = 0; s_on = 0; s_kr = 0; s_kf = 0; s_amp = 0; s_off = 0;
    endfunction

    function automatic void m_load();
        s_per = longint'(period);
        s_on  = longint'(on_time);
        s_kr  = longint'(k_rise);
        s_kf  = longint'(k_fall);
        s_amp = longint'(amp);
        s_off = longint'(offset);
    endfunction

    function automatic void m_step();
        if (rst) begin
            m_reset();
            return;
        end
        m_ps = 0;
        if (!clk_en) return;
        if (!m_run) begin
            if (enable && (!oneshot || trigger)) begin
                m_load();
                m_cnt = 0; m_v = 0; m_run = 1; m_ps = 1;
            end
        end else if (!enable) begin
            m_run = 0; m_cnt = 0; m_v = 0;
        end else if (m_cnt == s_per) begin
            m_cnt = 0;
            if (oneshot) begin
                m_run = 0; m_v = 0;
            end else begin
                m_load();
                m_ps = 1;
            end
        end else begin
            if (m_cnt >= s_on) m_v = (m_v > s_kf) ? m_v - s_kf : 0;
            else               m_v = (m_v + s_kr < s_amp) ? m_v + s_kr : s_amp;
            m_cnt++;
        end
    endfunction

    function automatic longint m_out();
        longint e;
        e = m_v + s_off;
        if (e > OUT_MAX) e = OUT_MAX;
        if (e < OUT_MIN) e = OUT_MIN;
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected sample per clock cycle, compared away from posedge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("out_o", longint'(out), mon_e.out);
            chk("period_start_o", longint'(pstart), longint'(mon_e.ps));
            chk("busy_o", longint'(busy), longint'(mon_e.busy));
        end
    end

    // Called at negedge+1 with inputs stable; predicts state after next posedge
    task automatic cyc();
        exp_t e;
        m_step();
        e.out  = m_out();
        e.ps   = m_ps;
        e.busy = m_run;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic cfg(input longint p, input longint o, input longint kr,
                       input longint kf, input longint a, input longint off);
        period  = CW'(p);
        on_time = CW'(o);
        k_rise  = W'(kr);
        k_fall  = W'(kf);
        amp     = W'(a);
        offset  = (W+1)'(off);
    endtask

    initial begin
        rst = 1; clk_en = 1; enable = 0; oneshot = 0; trigger = 0;
        cfg(0, 0, 0, 0, 0, 0);
        m_reset();
        #2;
        chk("reset out_o", longint'(out), 0);
        chk("reset busy_o", longint'(busy), 0);
        chk("reset period_start_o", longint'(pstart), 0);
        @(negedge clk); #1;
        rst = 0;

        // Continuous trapezoid
        enable = 1;
        cfg(9, 5, 40, 30, 100, 0);
        run(25);

        // Saturation: positive clamp, negative rail, negative offset in LOW
        cfg(9, 5, 65535, 65535, 65535, 40000);
        run(22);
        cfg(9, 5, 65535, 65535, 65535, -65536);
        run(22);
        cfg(9, 5, 40, 30, 100, -100);
        run(22);

        // One-shot with an ignored retrigger
        enable = 0; cyc();
        oneshot = 1; enable = 1;
        cfg(9, 5, 40, 30, 100, 0);
        run(3);
        trigger = 1; cyc(); trigger = 0;
        run(3);
        trigger = 1; cyc(); trigger = 0;
        run(12);
        trigger = 1; cyc(); trigger = 0;
        run(12);

        // Shadow update mid-period
        oneshot = 0;
        cfg(9, 5, 40, 30, 100, 0);
        cyc();
        run(3);
        amp = 50;
        run(22);

        // Clock-enable freeze, async reset mid-FALL, disable
        enable = 0; cyc();
        enable = 1;
        cfg(9, 5, 10, 15, 100, 0);
        run(3);
        clk_en = 0; run(5);
        clk_en = 1; run(4);
        rst = 1;
        #1;
        chk("async reset out_o", longint'(out), 0);
        chk("async reset busy_o", longint'(busy), 0);
        m_reset();
        cyc();
        rst = 0;
        run(6);
        enable = 0; run(2);

        // on_time beyond period: plateau held across wraps
        enable = 1;
        cfg(9, 20, 50, 30, 100, 0);
        run(25);

        // Randomised segments
        for (int seg = 0; seg < 40; seg++) begin
            oneshot = ($urandom_range(0, 2) == 0);
            cfg($urandom_range(0, 12),
                ($urandom_range(0, 5) == 0) ? longint'($urandom) : longint'($urandom_range(0, 14)),
                ($urandom_range(0, 3) == 0) ? longint'($urandom) : longint'($urandom_range(0, 3000)),
                ($urandom_range(0, 3) == 0) ? longint'($urandom) : longint'($urandom_range(0, 3000)),
                longint'($urandom),
                longint'($urandom));
            for (int c = 0, n = $urandom_range(5, 25); c < n; c++) begin
                clk_en  = ($urandom_range(0, 9) != 0);
                enable  = ($urandom_range(0, 19) != 0);
                trigger = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 7) == 0) amp = W'($urandom);
                if ($urandom_range(0, 7) == 0) offset = (W+1)'($urandom);
                cyc();
            end
        end
        clk_en = 1; trigger = 0;
        run(3);

        chk("scoreboard drained", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
